// File: rtl/cellram_pkg.sv
// Shared types and constants for the cellular RAM bus responder.
package cellram_pkg;

    localparam int unsigned CELLRAM_AW = 23;
    localparam int unsigned CELLRAM_DW = 16;
    localparam int unsigned CELLRAM_CW = 4;

    typedef enum logic [1:0] {
        StIdle,
        StRdWait,
        StRdDrive,
        StWrPulse
    } cellram_state_e;

    // Active-low byte enables: a deasserted lane reads back as zero.
    function automatic logic [CELLRAM_DW-1:0] cellram_lanes(
        input logic [CELLRAM_DW-1:0] word,
        input logic                  lb_n,
        input logic                  ub_n
    );
        logic [CELLRAM_DW-1:0] res;
        res       = word;
        if (lb_n) res[7:0]  = 8'h00;
        if (ub_n) res[15:8] = 8'h00;
        return res;
    endfunction

endpackage

// File: rtl/cellram_resp_mem.sv
// Single-port synchronous backing store with per-byte write enables and 1-clock read.
module cellram_resp_mem
    import cellram_pkg::*;
#(
    parameter int unsigned ADDR_W = 10
) (
    input  logic                  clk,
    input  logic [ADDR_W-1:0]     addr,
    input  logic [1:0]            we,
    input  logic [CELLRAM_DW-1:0] wdata,
    output logic [CELLRAM_DW-1:0] rdata
);

    logic [CELLRAM_DW-1:0] mem_q [2**ADDR_W];
    logic [CELLRAM_DW-1:0] rdata_d;
    logic [CELLRAM_DW-1:0] rdata_q;

    always_comb begin
        rdata_d = mem_q[addr];
    end

    always_ff @(posedge clk) begin
        if (we[0]) mem_q[addr][7:0]  <= wdata[7:0];
        if (we[1]) mem_q[addr][15:8] <= wdata[15:8];
        rdata_q <= rdata_d;
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/cellram_responder.sv
// Device-side model of the async-mode cellular RAM bus, backed by block RAM.
// Define CELLRAM_RESPONDER_CHECK_EN to add the proto_err / err_cnt protocol monitor.
module cellram_responder
    import cellram_pkg::*;
#(
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned RD_LAT = 4,
    parameter int unsigned WR_MIN = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  RamAdv,
    input  logic                  RamClk,
    input  logic                  RamCS,
    input  logic                  MemOE,
    input  logic                  MemWR,
    input  logic                  RamLB,
    input  logic                  RamUB,
    input  logic [CELLRAM_AW-1:0] MemAdr,
    input  logic [CELLRAM_DW-1:0] MemDB_in,
    output logic [CELLRAM_DW-1:0] MemDB_out,
    output logic                  MemDB_oe,
    output logic                  busy
`ifdef CELLRAM_RESPONDER_CHECK_EN
    ,
    output logic                  proto_err,
    output logic [7:0]            err_cnt
`endif
);

    localparam int unsigned CW  = CELLRAM_CW;
    localparam int unsigned CW1 = CELLRAM_CW + 1;
    localparam logic [CW-1:0] RdLast = CW'(RD_LAT - 1);
    localparam logic [CW:0]   WrMinL = CW1'(WR_MIN);

    cellram_state_e        state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [CELLRAM_AW-1:0] adr_q, adr_d;
    logic [CELLRAM_DW-1:0] rd_word_q, rd_word_d;
    logic                  oe_q, oe_d;
    logic [CELLRAM_DW-1:0] wdata_q, wdata_d;
    logic [1:0]            wbe_n_q, wbe_n_d;

    logic                  adv_hit, acc_wr, acc_rd, new_adr, wr_long, commit;
    logic [1:0]            mem_we;
    logic [ADDR_W-1:0]     mem_addr;
    logic [CELLRAM_DW-1:0] mem_rdata;
    logic                  unused_ramclk;

    assign unused_ramclk = RamClk;

    always_comb begin
        adv_hit = !RamAdv && !RamCS;
        acc_wr  = !RamCS && !MemWR;
        acc_rd  = !RamCS && !MemOE;
        new_adr = adv_hit && (MemAdr != adr_q);
        // The edge that enters WR_PULSE also saw MemWR low, hence the +1.
        wr_long = ({1'b0, cnt_q} + CW1'(1)) >= WrMinL;
        adr_d   = adv_hit ? MemAdr : adr_q;

        state_d   = state_q;
        cnt_d     = cnt_q;
        rd_word_d = rd_word_q;
        oe_d      = oe_q;
        wdata_d   = wdata_q;
        wbe_n_d   = wbe_n_q;
        commit    = 1'b0;

        if (acc_wr && (state_q != StWrPulse)) begin
            // A write pre-empts any read phase and never drives the bus.
            state_d = StWrPulse;
            cnt_d   = '0;
            oe_d    = 1'b0;
            wdata_d = MemDB_in;
            wbe_n_d = {RamUB, RamLB};
        end else begin
            unique case (state_q)
                StIdle: begin
                    oe_d = 1'b0;
                    if (acc_rd) begin
                        state_d = StRdWait;
                        cnt_d   = '0;
                    end
                end
                StRdWait: begin
                    if (!acc_rd) begin
                        state_d = StIdle;
                    end else if (new_adr) begin
                        cnt_d = '0;
                    end else if (cnt_q == RdLast) begin
                        rd_word_d = mem_rdata;
                        oe_d      = 1'b1;
                        state_d   = StRdDrive;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                StRdDrive: begin
                    // oe_q is held here and cleared by IDLE one edge later.
                    if (!acc_rd) begin
                        state_d = StIdle;
                    end else if (new_adr) begin
                        state_d = StRdWait;
                        cnt_d   = '0;
                        oe_d    = 1'b0;
                    end
                end
                StWrPulse: begin
                    if (acc_wr) begin
                        if (cnt_q != '1) cnt_d = cnt_q + CW'(1);
                        wdata_d = MemDB_in;
                        wbe_n_d = {RamUB, RamLB};
                    end else begin
                        commit  = wr_long;
                        state_d = StIdle;
                    end
                end
            endcase
        end

        mem_we   = (commit && !rst) ? ~wbe_n_q : 2'b00;
        mem_addr = (state_q == StWrPulse) ? adr_q[ADDR_W-1:0] : adr_d[ADDR_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            adr_q     <= '0;
            rd_word_q <= '0;
            oe_q      <= 1'b0;
            wdata_q   <= '0;
            wbe_n_q   <= 2'b11;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            adr_q     <= adr_d;
            rd_word_q <= rd_word_d;
            oe_q      <= oe_d;
            wdata_q   <= wdata_d;
            wbe_n_q   <= wbe_n_d;
        end
    end

    cellram_resp_mem #(
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk   (clk),
        .addr  (mem_addr),
        .we    (mem_we),
        .wdata (wdata_q),
        .rdata (mem_rdata)
    );

    assign MemDB_out = cellram_lanes(rd_word_q, RamLB, RamUB);
    assign MemDB_oe  = oe_q;
    assign busy      = (state_q != StIdle);

`ifdef CELLRAM_RESPONDER_CHECK_EN
    logic       ovl, drift, short_wr, err_ev;
    logic       ovl_q, ovl_d, drift_q, drift_d;
    logic       proto_err_q, proto_err_d;
    logic [7:0] err_cnt_q, err_cnt_d;

    always_comb begin
        ovl      = !RamCS && !MemOE && !MemWR;
        drift    = (state_q != StIdle) && RamAdv && (MemAdr != adr_q);
        short_wr = (state_q == StWrPulse) && !acc_wr && !wr_long;
        // Level conditions are logged once per occurrence, not once per clock.
        err_ev      = short_wr || (ovl && !ovl_q) || (drift && !drift_q);
        ovl_d       = ovl;
        drift_d     = drift;
        proto_err_d = proto_err_q || err_ev;
        err_cnt_d   = (err_ev && (err_cnt_q != 8'hFF)) ? err_cnt_q + 8'd1 : err_cnt_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ovl_q       <= 1'b0;
            drift_q     <= 1'b0;
            proto_err_q <= 1'b0;
            err_cnt_q   <= 8'h00;
        end else begin
            ovl_q       <= ovl_d;
            drift_q     <= drift_d;
            proto_err_q <= proto_err_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign proto_err = proto_err_q;
    assign err_cnt   = err_cnt_q;
`endif

endmodule

// File: tb/tb_cellram_responder.sv
// Scoreboard bench for cellram_responder; also checks proto_err/err_cnt when
// CELLRAM_RESPONDER_CHECK_EN is defined.
module tb_cellram_responder;

    localparam int unsigned ADDR_W = 10;
    localparam int unsigned RD_LAT = 4;
    localparam int unsigned WR_MIN = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        RamAdv = 1'b1, RamClk = 1'b0, RamCS = 1'b1, MemOE = 1'b1, MemWR = 1'b1;
    logic        RamLB = 1'b1, RamUB = 1'b1;
    logic [22:0] MemAdr = '0;
    logic [15:0] MemDB_in = '0;
    logic [15:0] MemDB_out;
    logic        MemDB_oe, busy;
`ifdef CELLRAM_RESPONDER_CHECK_EN
    logic        proto_err;
    logic [7:0]  err_cnt;
`endif

    int          n_total = 0;
    int          n_bad = 0;
    logic [15:0] exp_q [$];
    logic [15:0] model [int];

    always #5 clk = ~clk;

    cellram_responder #(
        .ADDR_W (ADDR_W),
        .RD_LAT (RD_LAT),
        .WR_MIN (WR_MIN)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .RamAdv    (RamAdv),
        .RamClk    (RamClk),
        .RamCS     (RamCS),
        .MemOE     (MemOE),
        .MemWR     (MemWR),
        .RamLB     (RamLB),
        .RamUB     (RamUB),
        .MemAdr    (MemAdr),
        .MemDB_in  (MemDB_in),
        .MemDB_out (MemDB_out),
        .MemDB_oe  (MemDB_oe),
        .busy      (busy)
`ifdef CELLRAM_RESPONDER_CHECK_EN
        ,
        .proto_err (proto_err),
        .err_cnt   (err_cnt)
`endif
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] lanes(input logic [15:0] w, input logic lb_n, input logic ub_n);
        logic [15:0] r;
        r = w;
        if (lb_n) r[7:0] = 8'h00;
        if (ub_n) r[15:8] = 8'h00;
        return r;
    endfunction

    function automatic logic [15:0] model_get(input int key);
        return model.exists(key) ? model[key] : 16'h0000;
    endfunction

    task automatic bus_idle();
        RamCS = 1'b1; MemOE = 1'b1; MemWR = 1'b1; RamAdv = 1'b1; RamLB = 1'b1; RamUB = 1'b1;
    endtask

    task automatic do_write(input string tag, input logic [22:0] a, input logic [15:0] d,
                            input logic lb_n, input logic ub_n, input int clks,
                            input logic with_oe);
        int          key;
        logic [15:0] w;
        @(negedge clk);
        RamCS = 1'b0; RamAdv = 1'b0; MemWR = 1'b0; MemOE = !with_oe;
        MemAdr = a; MemDB_in = d; RamLB = lb_n; RamUB = ub_n;
        repeat (clks) begin
            @(negedge clk);
            if (with_oe) check_eq({tag, "_oe"}, 32'(MemDB_oe), 32'd0);
        end
        bus_idle();
        @(negedge clk);
        check_eq({tag, "_busy"}, 32'(busy), 32'd0);
        if (clks >= int'(WR_MIN)) begin
            key = int'(a[ADDR_W-1:0]);
            w   = model_get(key);
            if (!lb_n) w[7:0] = d[7:0];
            if (!ub_n) w[15:8] = d[15:8];
            model[key] = w;
        end
    endtask

    task automatic do_read(input string tag, input logic [22:0] a,
                           input logic lb_n, input logic ub_n);
        int          lat;
        logic [15:0] e;
        exp_q.push_back(lanes(model_get(int'(a[ADDR_W-1:0])), lb_n, ub_n));
        @(negedge clk);
        RamCS = 1'b0; MemOE = 1'b0; RamAdv = 1'b0; MemAdr = a; RamLB = lb_n; RamUB = ub_n;
        lat = -1;
        for (int k = 0; k < 32; k++) begin
            @(negedge clk);
            if (MemDB_oe === 1'b1) begin
                lat = k;
                break;
            end
        end
        check_eq({tag, "_lat"}, 32'(lat), 32'(RD_LAT));
        e = exp_q.pop_front();
        check_eq({tag, "_data"}, 32'(MemDB_out), 32'(e));
        bus_idle();
        repeat (2) @(negedge clk);
        check_eq({tag, "_turn"}, 32'({busy, MemDB_oe}), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus_idle();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("rst_out", 32'(MemDB_out), 32'd0);
        check_eq("rst_oe", 32'(MemDB_oe), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
`ifdef CELLRAM_RESPONDER_CHECK_EN
        check_eq("rst_perr", 32'(proto_err), 32'd0);
        check_eq("rst_ecnt", 32'(err_cnt), 32'd0);
`endif
        rst = 1'b0;

        do_write("w_beef", 23'h5, 16'hBEEF, 1'b0, 1'b0, 3, 1'b0);
        @(negedge clk) rst = 1'b1;
        @(negedge clk) rst = 1'b0;
        do_read("r_beef", 23'h5, 1'b0, 1'b0);

        do_write("w_1234", 23'h10, 16'h1234, 1'b0, 1'b0, 3, 1'b0);
        do_read("r_1234", 23'h10, 1'b0, 1'b0);

        do_write("w_ub", 23'h10, 16'hAB00, 1'b1, 1'b0, 3, 1'b0);
        do_read("r_ab34", 23'h10, 1'b0, 1'b0);
        do_read("r_lbmask", 23'h10, 1'b1, 1'b0);

        do_write("w_short", 23'h10, 16'h7777, 1'b0, 1'b0, 2, 1'b0);
        do_read("r_short", 23'h10, 1'b0, 1'b0);
`ifdef CELLRAM_RESPONDER_CHECK_EN
        check_eq("short_perr", 32'(proto_err), 32'd1);
        check_eq("short_ecnt", 32'(err_cnt), 32'd1);
`endif

        do_write("w_ovl", 23'h30, 16'h5555, 1'b0, 1'b0, 3, 1'b1);
        do_read("r_ovl", 23'h30, 1'b0, 1'b0);
`ifdef CELLRAM_RESPONDER_CHECK_EN
        check_eq("ovl_ecnt", 32'(err_cnt), 32'd2);
`endif

        do_write("w_noben", 23'h30, 16'hFFFF, 1'b1, 1'b1, 3, 1'b0);
        do_read("r_noben", 23'h30, 1'b0, 1'b0);

        do_write("w_0a0a", 23'h20, 16'h0A0A, 1'b0, 1'b0, 3, 1'b0);
        @(negedge clk);
        RamCS = 1'b0; RamAdv = 1'b0; MemWR = 1'b0; MemAdr = 23'h20; MemDB_in = 16'hFFFF;
        RamLB = 1'b0; RamUB = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("rstwr_busy_pre", 32'(busy), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check_eq("rstwr_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        bus_idle();
        @(negedge clk);
        do_read("r_rstwr", 23'h20, 1'b0, 1'b0);

        do_read("r_alias", 23'h400410, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
